// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing decoder: recovers active-pixel coordinates from the sync/blank
// pins, measures line and frame lengths, and tracks lock against the nominal timing.
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 1040,
  parameter int unsigned V_TOTAL     = 666,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        hSync_n,
  input  logic        vSync_n,
  input  logic        blank_n,
  output logic [10:0] pixelX,
  output logic [9:0]  pixelY,
  output logic        pixelValid,
  output logic        frameStart,
  output logic [10:0] lineLength,
  output logic [9:0]  frameLines,
  output logic        locked,
  output logic        timingError
);

  localparam logic [10:0] H_NOM  = 11'(H_TOTAL);
  localparam logic [9:0]  V_NOM  = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_s_q, hs_s_d, vs_s_q, vs_s_d, bl_s_q, bl_s_d;
  logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d, bl_p_q, bl_p_d;
  logic [10:0] hrun_q, hrun_d;
  logic [9:0]  vrun_q, vrun_d;
  logic        h_seen_q, h_seen_d;
  logic        bad_frame_q, bad_frame_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        pv_q, pv_d;
  logic        fs_q, fs_d;
  logic [10:0] ll_q, ll_d;
  logic [9:0]  fl_q, fl_d;
  logic        locked_q, locked_d;
  logic        terr_q, terr_d;

  logic        h_fall, v_fall, bl_fall, judged, bad_line, frame_good;
  logic [10:0] line_len;
  logic [3:0]  good_inc;

  always_comb begin
    hs_s_d      = hSync_n;
    vs_s_d      = vSync_n;
    bl_s_d      = blank_n;
    hs_p_d      = hs_s_q;
    vs_p_d      = vs_s_q;
    bl_p_d      = bl_s_q;
    hrun_d      = hrun_q;
    vrun_d      = vrun_q;
    h_seen_d    = h_seen_q;
    bad_frame_d = bad_frame_q;
    good_cnt_d  = good_cnt_q;
    state_d     = state_q;
    px_d        = '0;
    py_d        = py_q;
    fs_d        = 1'b0;
    ll_d        = ll_q;
    fl_d        = fl_q;
    locked_d    = locked_q;
    terr_d      = 1'b0;

    h_fall   = hs_p_q & ~hs_s_q;
    v_fall   = vs_p_q & ~vs_s_q;
    bl_fall  = bl_p_q & ~bl_s_q;
    line_len = (hrun_q == '1) ? hrun_q : hrun_q + 11'd1;
    judged   = h_fall & h_seen_q;
    bad_line = judged && (line_len != H_NOM);
    // A bad line ending in the vsync cycle still belongs to the frame being closed.
    frame_good = !(bad_frame_q || bad_line) && (vrun_q == V_NOM);
    good_inc   = {1'b0, good_cnt_q} + 4'd1;

    if (h_fall) begin
      hrun_d   = '0;
      h_seen_d = 1'b1;
    end else if (hrun_q != '1) begin
      hrun_d = hrun_q + 11'd1;
    end
    if (judged) ll_d = line_len;

    if (v_fall) begin
      fl_d   = vrun_q;
      vrun_d = h_fall ? 10'd1 : 10'd0;
      fs_d   = 1'b1;
    end else if (h_fall && (vrun_q != '1)) begin
      vrun_d = vrun_q + 10'd1;
    end

    if (v_fall)        bad_frame_d = 1'b0;
    else if (bad_line) bad_frame_d = 1'b1;

    case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d    = MEASURE;
          good_cnt_d = '0;
        end
      end
      MEASURE: begin
        if (v_fall) begin
          if (frame_good) begin
            good_cnt_d = (good_inc > 4'd7) ? 3'd7 : good_inc[2:0];
            if (good_inc >= LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        // Missing vsync shows up as vRun pinned at its ceiling.
        if (bad_line || (v_fall && !frame_good) || (!v_fall && (vrun_q == '1))) begin
          terr_d     = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
          state_d    = MEASURE;
        end
      end
      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    endcase

    if (bl_s_q && bl_p_q && (px_q != '1)) px_d = px_q + 11'd1;
    else if (bl_s_q && bl_p_q)            px_d = px_q;

    if (v_fall)                         py_d = '0;
    else if (bl_fall && (py_q != '1))   py_d = py_q + 10'd1;

    pv_d = bl_s_q & locked_d;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hs_s_q      <= 1'b1;
      vs_s_q      <= 1'b1;
      bl_s_q      <= 1'b1;
      hs_p_q      <= 1'b1;
      vs_p_q      <= 1'b1;
      bl_p_q      <= 1'b1;
      hrun_q      <= '0;
      vrun_q      <= '0;
      h_seen_q    <= 1'b0;
      bad_frame_q <= 1'b0;
      good_cnt_q  <= '0;
      state_q     <= SEARCH;
      px_q        <= '0;
      py_q        <= '0;
      pv_q        <= 1'b0;
      fs_q        <= 1'b0;
      ll_q        <= '0;
      fl_q        <= '0;
      locked_q    <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      hs_s_q      <= hs_s_d;
      vs_s_q      <= vs_s_d;
      bl_s_q      <= bl_s_d;
      hs_p_q      <= hs_p_d;
      vs_p_q      <= vs_p_d;
      bl_p_q      <= bl_p_d;
      hrun_q      <= hrun_d;
      vrun_q      <= vrun_d;
      h_seen_q    <= h_seen_d;
      bad_frame_q <= bad_frame_d;
      good_cnt_q  <= good_cnt_d;
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pv_q        <= pv_d;
      fs_q        <= fs_d;
      ll_q        <= ll_d;
      fl_q        <= fl_d;
      locked_q    <= locked_d;
      terr_q      <= terr_d;
    end
  end

  assign pixelX      = px_q;
  assign pixelY      = py_q;
  assign pixelValid  = pv_q;
  assign frameStart  = fs_q;
  assign lineLength  = ll_q;
  assign frameLines  = fl_q;
  assign locked      = locked_q;
  assign timingError = terr_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down raster (20 clocks x 12 lines,
// 10x6 active) so lock, error and saturation scenarios fit in a short run.
module tb_vga_timing_monitor;

  localparam int HT = 20, VT = 12;
  localparam int HA = 10, HS0 = 13, HS1 = 16;
  localparam int VA = 6,  VS0 = 8,  VS1 = 10;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        hSync_n = 1'b1, vSync_n = 1'b1, blank_n = 1'b1;
  logic [10:0] pixelX, lineLength;
  logic [9:0]  pixelY, frameLines;
  logic        pixelValid, frameStart, locked, timingError;

  int checks = 0, errors = 0;
  int gh = 0, gv = 0, line_len = HT, frame_len = VT;
  bit vs_en = 1'b1;
  int cur_h = 0, cur_v = 0, exp_h = 0, exp_v = 0;
  bit cur_b = 1'b0, exp_b = 1'b0;

  always #5 Clock = ~Clock;

  vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
    .Clock(Clock), .Reset(Reset), .hSync_n(hSync_n), .vSync_n(vSync_n), .blank_n(blank_n),
    .pixelX(pixelX), .pixelY(pixelY), .pixelValid(pixelValid), .frameStart(frameStart),
    .lineLength(lineLength), .frameLines(frameLines), .locked(locked), .timingError(timingError)
  );

  // Drive one raster position, clock it in, and sample outputs #1 after the edge.
  // Outputs then reflect the pins driven one tick earlier (exp_*).
  task automatic tick();
    bit b;
    b = (gh < HA) && (gv < VA);
    hSync_n = !((gh >= HS0) && (gh < HS1));
    vSync_n = !(vs_en && (gv >= VS0) && (gv < VS1));
    blank_n = b;
    @(posedge Clock);
    #1;
    exp_h = cur_h; exp_v = cur_v; exp_b = cur_b;
    cur_h = gh;    cur_v = gv;    cur_b = b;
    gh++;
    if (gh >= line_len) begin
      gh = 0; line_len = HT; gv++;
      if (gv >= frame_len) begin gv = 0; frame_len = VT; end
    end
  endtask

  task automatic wait_fs(input int max_ticks, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_ticks; i++) begin
      tick();
      if (frameStart === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic advance_to(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (gh == h && gv == v) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if ({pixelValid, frameStart, locked, timingError} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {pixelValid, frameStart, locked, timingError}); end
    checks++; if (pixelX !== 11'd0 || pixelY !== 10'd0) begin errors++;
      $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", pixelX, pixelY); end
    checks++; if (lineLength !== 11'd0 || frameLines !== 10'd0) begin errors++;
      $display("FAIL reset_lengths: got %0d/%0d expected 0/0", lineLength, frameLines); end
    Reset = 1'b0;
    gh = 0; gv = 0;
  endtask

  task automatic test_nominal_lock();
    bit ok;
    bit [2:0] lk;
    lk = '0;
    for (int i = 0; i < 3; i++) begin
      wait_fs(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lock_fs%0d_timeout: got none expected frameStart", i + 1); end
      lk[i] = locked;
      if (i == 0) begin
        checks++; if (frameLines !== 10'd8) begin errors++;
          $display("FAIL first_frame_lines: got %0d expected 8", frameLines); end
        checks++; if (lineLength !== 11'd20) begin errors++;
          $display("FAIL first_line_length: got %0d expected 20", lineLength); end
      end
    end
    checks++; if (lk !== 3'b100) begin errors++;
      $display("FAIL lock_at_third_fs: got %b expected 100", lk); end
    checks++; if (lineLength !== 11'd20 || frameLines !== 10'd12) begin errors++;
      $display("FAIL nominal_lengths: got %0d/%0d expected 20/12", lineLength, frameLines); end
    tick();
    checks++; if (frameStart !== 1'b0) begin errors++;
      $display("FAIL frame_start_width: got %b expected 0", frameStart); end
  endtask

  task automatic test_coordinates();
    int valid = 0, bad = 0, ymin = 1023, ymax = -1, xmax = -1;
    int bad_h = 0, bad_v = 0;
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (frameStart === 1'b1) begin ok = 1'b1; break; end
      if (pixelValid !== exp_b || pixelX !== 11'(exp_b ? exp_h : 0) ||
          (exp_b && pixelY !== 10'(exp_v))) begin
        if (bad == 0) begin bad_h = exp_h; bad_v = exp_v; end
        bad++;
      end
      if (pixelValid === 1'b1) begin
        valid++;
        if (int'(pixelY) < ymin) ymin = int'(pixelY);
        if (int'(pixelY) > ymax) ymax = int'(pixelY);
        if (int'(pixelX) > xmax) xmax = int'(pixelX);
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL coord_frame_timeout: got none expected frameStart"); end
    checks++; if (valid != HA * VA) begin errors++;
      $display("FAIL valid_cycles: got %0d expected %0d", valid, HA * VA); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL coord_lag: got %0d bad cycles (first at h=%0d v=%0d) expected 0", bad, bad_h, bad_v); end
    checks++; if (ymin != 0 || ymax != VA - 1) begin errors++;
      $display("FAIL pixel_y_range: got %0d..%0d expected 0..%0d", ymin, ymax, VA - 1); end
    checks++; if (xmax != HA - 1) begin errors++;
      $display("FAIL pixel_x_max: got %0d expected %0d", xmax, HA - 1); end
  endtask

  task automatic test_long_line();
    bit ok;
    int err_cycles = 0, fs_n = 0;
    logic [10:0] ll_at = '0;
    logic lk_at = 1'b1;
    bit [2:0] lk = '0;
    advance_to(0, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_line_setup: got timeout expected position"); end
    line_len = HT + 1;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (timingError === 1'b1) begin err_cycles++; ll_at = lineLength; lk_at = locked; end
      if (frameStart === 1'b1) begin
        lk[fs_n] = locked;
        fs_n++;
        if (fs_n == 3) break;
      end
    end
    checks++; if (err_cycles != 1) begin errors++;
      $display("FAIL long_line_error_cycles: got %0d expected 1", err_cycles); end
    checks++; if (ll_at !== 11'd21 || lk_at !== 1'b0) begin errors++;
      $display("FAIL long_line_state: got len=%0d locked=%b expected 21 0", ll_at, lk_at); end
    checks++; if (fs_n != 3 || lk !== 3'b100) begin errors++;
      $display("FAIL long_line_relock: got fs=%0d locked=%b expected 3 100", fs_n, lk); end
    checks++; if (lineLength !== 11'd20) begin errors++;
      $display("FAIL long_line_recovered: got %0d expected 20", lineLength); end
  endtask

  task automatic test_short_frame();
    bit ok;
    advance_to(0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_setup: got timeout expected position"); end
    frame_len = VT - 1;
    wait_fs(400, ok);
    checks++; if (!ok || frameLines !== 10'd12 || locked !== 1'b1 || timingError !== 1'b0) begin errors++;
      $display("FAIL pre_short_frame: got lines=%0d locked=%b err=%b expected 12 1 0", frameLines, locked, timingError); end
    wait_fs(400, ok);
    checks++; if (!ok || frameLines !== 10'd11) begin errors++;
      $display("FAIL short_frame_lines: got %0d expected 11", frameLines); end
    checks++; if (timingError !== 1'b1 || locked !== 1'b0) begin errors++;
      $display("FAIL short_frame_error: got err=%b locked=%b expected 1 0", timingError, locked); end
    wait_fs(400, ok);
    wait_fs(400, ok);
    checks++; if (locked !== 1'b1) begin errors++;
      $display("FAIL short_frame_relock: got %b expected 1", locked); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit [2:0] lk = '0;
    advance_to(5, 3, ok);
    checks++; if (!ok || locked !== 1'b1) begin errors++;
      $display("FAIL midreset_setup: got ok=%b locked=%b expected 1 1", ok, locked); end
    #2 Reset = 1'b1;
    #1;
    checks++; if ({pixelValid, frameStart, locked, timingError} !== 4'b0 || pixelX !== 11'd0 ||
                  pixelY !== 10'd0 || lineLength !== 11'd0 || frameLines !== 10'd0) begin errors++;
      $display("FAIL midreset_async: got x=%0d y=%0d len=%0d lines=%0d flags=%b expected all 0",
               pixelX, pixelY, lineLength, frameLines, {pixelValid, frameStart, locked, timingError}); end
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    checks++; if (frameStart !== 1'b0 || timingError !== 1'b0 || locked !== 1'b0) begin errors++;
      $display("FAIL midreset_release: got fs=%b err=%b locked=%b expected 0 0 0", frameStart, timingError, locked); end
    for (int i = 0; i < 3; i++) begin
      wait_fs(400, ok);
      lk[i] = locked;
      if (i == 0) begin
        checks++; if (frameLines !== 10'd5) begin errors++;
          $display("FAIL midreset_first_lines: got %0d expected 5", frameLines); end
      end
    end
    checks++; if (lk !== 3'b100) begin errors++;
      $display("FAIL midreset_relock: got %b expected 100", lk); end
  endtask

  task automatic test_sync_free();
    int err_cycles = 0, fs_cnt = 0, post = 0;
    logic lk_at = 1'b1;
    vs_en = 1'b0;
    for (int i = 0; i < 21500; i++) begin
      tick();
      if (frameStart === 1'b1) fs_cnt++;
      if (timingError === 1'b1) begin err_cycles++; lk_at = locked; end
      if (err_cycles > 0) post++;
      if (post >= 100) break;
    end
    checks++; if (err_cycles != 1) begin errors++;
      $display("FAIL syncfree_error_cycles: got %0d expected 1", err_cycles); end
    checks++; if (fs_cnt != 0) begin errors++;
      $display("FAIL syncfree_frame_start: got %0d expected 0", fs_cnt); end
    checks++; if (lk_at !== 1'b0 || locked !== 1'b0) begin errors++;
      $display("FAIL syncfree_locked: got %b/%b expected 0/0", lk_at, locked); end
    checks++; if (frameLines !== 10'd12 || lineLength !== 11'd20) begin errors++;
      $display("FAIL syncfree_lengths: got %0d/%0d expected 12/20", frameLines, lineLength); end
    vs_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_coordinates();
    test_long_line();
    test_short_frame();
    test_reset_mid_frame();
    test_sync_free();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
